// File: rtl/sonar_ranger_if.sv
// sonar_ranger_if: ranging controller pins (enable/echo in, trig/dist_word/valid/busy out); slave = controller, master = sensor-block side
interface sonar_ranger_if;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [31:0] dist_word;
  logic        valid;
  logic        busy;
  modport master (output enable, echo, input trig, dist_word, valid, busy);
  modport slave  (input enable, echo, output trig, dist_word, valid, busy);
endinterface

// File: rtl/sonar_ranger.sv
// sonar_ranger: trigger/echo-width ranging controller; ports clk, reset (sync active-high), bus (sonar_ranger_if.slave); word {timeout, seq[6:0], 2'b0, width[21:0]}; SONAR_MEDIAN3_EN enables median-of-3 width filter
module sonar_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int CNT_W          = 22
) (
  input logic clk,
  input logic reset,
  sonar_ranger_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_W      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, per_q, per_d, pub_w, filt_w;
  logic [6:0] seq_q, seq_d;
  logic [31:0] word_q, word_d;
  logic trig_q, trig_d, valid_q, valid_d, pub, pub_to, echo_s, rise;
  // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the previous echo_s for edge detect
  assign sync_d = {sync_q[1:0], bus.echo};
  assign echo_s = sync_q[1];
  assign rise   = echo_s & ~sync_q[2];
  // tmr times TRIG, the WAIT_RISE timeout and the echo width; per runs from TRIG entry
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + ONE;
    per_d   = per_q + ONE;
    pub     = 1'b0;
    pub_to  = 1'b0;
    pub_w   = '0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        per_d = '0;
        state_d = bus.enable ? TRIG : IDLE;
      end
      TRIG: if (tmr_q == TRIG_LAST) begin
        state_d = WAIT_RISE;
        tmr_d = '0;
      end
      WAIT_RISE: if (rise) begin
        state_d = MEASURE;
        tmr_d = ONE;
      end else if (tmr_q == TO_LAST) begin
        state_d = HOLDOFF;
        pub = 1'b1;
        pub_to = 1'b1;
      end
      MEASURE: if (!echo_s) begin
        state_d = HOLDOFF;
        pub = 1'b1;
        pub_w = tmr_q;
      end else if (tmr_q == TO_LAST) begin
        state_d = HOLDOFF;
        pub = 1'b1;
        pub_to = 1'b1;
        pub_w = TO_W;
      end
      HOLDOFF: if (per_q == PER_LAST) begin
        state_d = bus.enable ? TRIG : IDLE;
        tmr_d = '0;
        per_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef SONAR_MEDIAN3_EN
  logic [CNT_W-1:0] h0_q, h0_d, h1_q, h1_d, lo, hi;
  logic [1:0] n_q, n_d;
  logic upd;
  always_comb begin
    lo     = pub_w < h0_q ? pub_w : h0_q;
    hi     = pub_w < h0_q ? h0_q : pub_w;
    filt_w = (!pub_to && n_q == 2'd2) ? (h1_q < lo ? lo : h1_q > hi ? hi : h1_q) : pub_w;
    upd    = pub & ~pub_to;
    h0_d   = upd ? pub_w : h0_q;
    h1_d   = upd ? h0_q : h1_q;
    n_d    = (upd && n_q != 2'd2) ? n_q + 2'd1 : n_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h0_q <= '0;
      h1_q <= '0;
      n_q  <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      n_q  <= n_d;
    end
  end
`else
  assign filt_w = pub_w;
`endif
  always_comb begin
    word_d  = pub ? {pub_to, seq_q, 2'b00, 22'(filt_w)} : word_q;
    valid_d = pub;
    seq_d   = seq_q + 7'(pub);
    trig_d  = state_q == TRIG;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      tmr_q   <= '0;
      per_q   <= '0;
      seq_q   <= '0;
      word_q  <= '0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tmr_q   <= tmr_d;
      per_q   <= per_d;
      seq_q   <= seq_d;
      word_q  <= word_d;
      trig_q  <= trig_d;
      valid_q <= valid_d;
    end
  end
  assign bus.trig      = trig_q;
  assign bus.dist_word = word_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = state_q != IDLE;
endmodule
